mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle MIPS32 main controller. Decodes the instruction register and sequences fetch, decode, execute, memory and writeback over 3–5 cycles.
- Drives the ALU's 4-bit opcode and the operand-select muxes, and consumes the ALU's zero and overflow flags.
- Sits beside the datapath and owns every register, PC and memory write-enable.

Parameters:
- RESET_VEC_SEL, 2'b00: PCSource value driven in IDLE (reset vector path).
- EXC_VEC_SEL, 2'b11: PCSource value selecting the exception-vector input.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result-is-zero flag (combinational from ALU)
- OFsign  in  1  ALU signed-overflow flag (combinational, valid for add)
- mem_ready  in  1  memory completes the current access this cycle
- ALUOp  out  4  0 nop, 1 add, 2 sub, 3 and, 4 or, 5 slt, 6 sll, 7 lui
- ALUSrcA  out  2  00 PC, 01 A reg (rs), 10 B reg (rt)
- ALUSrcB  out  3  000 B reg, 001 const 4, 010 sext imm, 011 sext imm<<2, 100 zext imm, 101 shamt
- IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCWrite, PCWriteCond  out  1 each
- PCSource  out  2  00 ALU result, 01 ALUOut reg, 10 jump target, 11 exception vector
- EPCWrite  out  1  capture PC into EPC
- ill_instr  out  1  one-cycle pulse on an undecodable instruction
- state_o  out  4  current state, for debug

Behaviour:
- **Reset:** async on rst_n=0. State goes to IDLE and every output is 0, except PCSource=RESET_VEC_SEL. IDLE goes to FETCH on the first clock after release. Reset mid-instruction abandons it; no partial writes occur after reset asserts.
- **Output style:** Moore. Outputs decode from the state register, and from the registered opcode/funct where noted.
- **FETCH:** MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=001, ALUOp=add, PCSource=00.
  - Holds while mem_ready=0.
  - In the cycle mem_ready=1: IRWrite=1, PCWrite=1, next state DECODE.
- **DECODE:** ALUSrcA=00, ALUSrcB=011, ALUOp=add (branch target into ALUOut). Dispatch:
  - R-type (opcode 0) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000 → REXEC.
  - addi 001000, ori 001101, lui 001111 → IEXEC.
  - lw 100011, sw 101011 → MEMADR.
  - beq 000100 → BRANCH.
  - j 000010 → JUMP.
  - Anything else: ill_instr=1 for this cycle, then FETCH. No writes.
- **REXEC:** ALUOp from funct.
  - sll: ALUSrcA=10, ALUSrcB=101.
  - All others: ALUSrcA=01, ALUSrcB=000.
  - Next RWB.
- **RWB:** RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- **IEXEC:** ALUSrcA=01.
  - addi: ALUSrcB=010, ALUOp=add.
  - ori: ALUSrcB=100, ALUOp=or.
  - lui: ALUSrcB=100, ALUOp=lui.
  - Next IWB.
- **IWB:** RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- **MEMADR:** ALUSrcA=01, ALUSrcB=010, ALUOp=add. Next MEMRD (lw) or MEMWR (sw).
- **MEMRD:** IorD=1, MemRead=1. Holds until mem_ready=1, then MEMWB.
- **MEMWB:** RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- **MEMWR:** IorD=1, MemWrite=1. Holds until mem_ready=1, then FETCH.
- **BRANCH:** ALUSrcA=01, ALUSrcB=000, ALUOp=sub, PCWriteCond=1, PCSource=01. The datapath gates with zero. Next FETCH.
- **JUMP:** PCWrite=1, PCSource=10. Next FETCH.
- **Overflow flag:** OFsign is sampled into ovf_q at the end of REXEC (add) and IEXEC (addi) only. ovf_q is cleared in FETCH.
- **Memory handshake:** MemRead/MemWrite stay asserted and stable until mem_ready is seen. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- **CPI:**
  - j, beq: 3 cycles.
  - R-type, I-type ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - All counts assume zero wait states.

Optional Feature:
- **OVF_TRAP_EN defined:**
  - In RWB/IWB with ovf_q=1: RegWrite=0, next state EXC instead of FETCH.
  - EXC: EPCWrite=1, PCWrite=1, PCSource=EXC_VEC_SEL, then FETCH.
  - sub never traps.
- **Undefined:** ovf_q and the EXC state are absent, EPCWrite is tied 0, and overflowing adds write back normally.

Decomposition:
- **Shared package (mips_pkg):**
  - ALU opcode constants (nop..lui, 0–7).
  - Opcode and funct constants.
  - State encoding, 4 bits.
  - ALUSrcA/ALUSrcB/PCSource select encodings.
- **Sub-module mc_ctrl_aludec:** combinational funct/opcode → ALUOp plus operand selects. It is shared with any future pipelined controller.

Test Plan:
- Reset then add $3=$1+$2, no wait states → IDLE, FETCH, DECODE, REXEC, RWB; ALUOp=1 in REXEC; RegWrite=1 only in RWB; 4 cycles after IDLE.
- lw with mem_ready low for 3 cycles in MEMRD → MemRead held 4 cycles with IorD=1; MemWB RegWrite=1 and MemtoReg=1 exactly once.
- beq with zero=1, then with zero=0 → PCWriteCond=1 and ALUOp=2 in BRANCH both times; FETCH follows in 3 cycles total.
- addi with OFsign=1 in IEXEC:
  - OVF_TRAP_EN set: RegWrite stays 0; next is EXC with EPCWrite=1 and PCSource=11.
  - Undefined: RegWrite=1 in IWB.
- opcode 111111 → ill_instr pulses 1 cycle in DECODE; no RegWrite/MemWrite; back to FETCH.
- rst_n low in MEMWR while mem_ready=0 → all enables 0 immediately; IDLE then FETCH after release.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS32 controller constants, state encoding and decode helpers (S_EXC present only with OVF_TRAP_EN)
package mips_pkg;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] SA_PC = 2'b00;
    localparam logic [1:0] SA_A  = 2'b01;
    localparam logic [1:0] SA_B  = 2'b10;

    localparam logic [2:0] SB_B     = 3'b000;
    localparam logic [2:0] SB_4     = 3'b001;
    localparam logic [2:0] SB_SEXT  = 3'b010;
    localparam logic [2:0] SB_SEXT2 = 3'b011;
    localparam logic [2:0] SB_ZEXT  = 3'b100;
    localparam logic [2:0] SB_SHAMT = 3'b101;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_EXC    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_REXEC, S_RWB, S_IEXEC, S_IWB,
        S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP
`ifdef OVF_TRAP_EN
        , S_EXC
`endif
    } state_e;

    function automatic logic [3:0] r_alu_op(input logic [5:0] fn);
        return fn == FN_ADD ? ALU_ADD : fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND :
               fn == FN_OR ? ALU_OR : fn == FN_SLT ? ALU_SLT : fn == FN_SLL ? ALU_SLL : ALU_NOP;
    endfunction

    // Returning S_FETCH means the instruction is not decodable.
    function automatic state_e dispatch(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL}) ? S_REXEC : S_FETCH;
            OP_ADDI, OP_ORI, OP_LUI: return S_IEXEC;
            OP_LW, OP_SW: return S_MEMADR;
            OP_BEQ: return S_BRANCH;
            OP_J: return S_JUMP;
            default: return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_aludec.sv
// mc_ctrl_aludec: state/opcode/funct to ALU opcode and operand selects
module mc_ctrl_aludec
    import mips_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b
);

    // ALU operation and operand muxes for each state
    always_comb begin
        alu_op = ALU_NOP;
        alu_src_a = SA_PC;
        alu_src_b = SB_B;
        case (state)
            S_FETCH: begin
                alu_op = ALU_ADD;
                alu_src_b = SB_4;
            end
            S_DECODE: begin
                alu_op = ALU_ADD;
                alu_src_b = SB_SEXT2;
            end
            S_REXEC: begin
                alu_op = r_alu_op(funct);
                alu_src_a = funct == FN_SLL ? SA_B : SA_A;
                alu_src_b = funct == FN_SLL ? SB_SHAMT : SB_B;
            end
            S_IEXEC: begin
                alu_op = opcode == OP_ORI ? ALU_OR : opcode == OP_LUI ? ALU_LUI : ALU_ADD;
                alu_src_a = SA_A;
                alu_src_b = opcode == OP_ADDI ? SB_SEXT : SB_ZEXT;
            end
            S_MEMADR: begin
                alu_op = ALU_ADD;
                alu_src_a = SA_A;
                alu_src_b = SB_SEXT;
            end
            S_BRANCH: begin
                alu_op = ALU_SUB;
                alu_src_a = SA_A;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS32 main controller; OVF_TRAP_EN enables the signed-overflow trap
module mc_ctrl
    import mips_pkg::*;
#(
    parameter logic [1:0] RESET_VEC_SEL = 2'b00,
    parameter logic [1:0] EXC_VEC_SEL   = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       OFsign,
    input  logic       mem_ready,
    output logic [3:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       EPCWrite,
    output logic       ill_instr,
    output logic [3:0] state_o
);

    state_e state, state_next;
    logic   unused_flags;

    assign state_o = state;
    assign unused_flags = &{1'b0, zero, OFsign};

    mc_ctrl_aludec u_aludec (
        .state     (state),
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (ALUOp),
        .alu_src_a (ALUSrcA),
        .alu_src_b (ALUSrcB)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_next;
    end

`ifdef OVF_TRAP_EN
    logic ovf_q;

    // Overflow of add/addi is remembered until writeback decides whether to trap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (state == S_FETCH) ovf_q <= 1'b0;
        else if ((state == S_REXEC && funct == FN_ADD) || (state == S_IEXEC && opcode == OP_ADDI)) ovf_q <= OFsign;
    end
`endif

    // Next-state and write-enable decode
    always_comb begin
        state_next = S_FETCH;
        IorD = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        RegDst = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        PCWrite = 1'b0;
        PCWriteCond = 1'b0;
        PCSource = PCS_ALU;
        EPCWrite = 1'b0;
        ill_instr = 1'b0;
        case (state)
            S_IDLE: PCSource = RESET_VEC_SEL;
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                state_next = dispatch(opcode, funct);
                ill_instr = state_next == S_FETCH;
            end
            S_REXEC: state_next = S_RWB;
            S_IEXEC: state_next = S_IWB;
            S_RWB, S_IWB: begin
                RegDst = state == S_RWB;
                RegWrite = 1'b1;
`ifdef OVF_TRAP_EN
                RegWrite = !ovf_q;
                state_next = ovf_q ? S_EXC : S_FETCH;
`endif
            end
            S_MEMADR: state_next = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                IorD = 1'b1;
                MemRead = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD = 1'b1;
                MemWrite = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_BRANCH: begin
                PCWriteCond = 1'b1;
                PCSource = PCS_ALUOUT;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSource = PCS_JUMP;
            end
`ifdef OVF_TRAP_EN
            S_EXC: begin
                EPCWrite = 1'b1;
                PCWrite = 1'b1;
                PCSource = EXC_VEC_SEL;
            end
`endif
            default: ;
        endcase
    end

endmodule
